// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hold/flush/redirect controller for the 5-stage RV64 core.
// Owns the divider-wait and trap-drain sequencing and a stall-cycle counter.
module pipe_hazard_ctrl #(
    parameter int ADDR_W      = 64,
    parameter int CNT_W       = 32,
    parameter int DIV_MAX_CYC = 70
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_reg1_read_i,
    input  logic [4:0]        id_reg1_raddr_i,
    input  logic              id_reg2_read_i,
    input  logic [4:0]        id_reg2_raddr_i,
    input  logic              ex_load_i,
    input  logic [4:0]        ex_wd_i,
    input  logic              jump_flag_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              div_start_i,
    input  logic              div_ready_i,
    input  logic              trap_req_i,
    input  logic [ADDR_W-1:0] trap_vec_i,
    output logic              hold_pc_o,
    output logic              hold_if_id_o,
    output logic              hold_id_ex_o,
    output logic              flush_if_id_o,
    output logic              flush_id_ex_o,
    output logic              redirect_o,
    output logic [ADDR_W-1:0] redirect_addr_o,
    output logic              div_kill_o,
    output logic              div_timeout_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    typedef enum logic [1:0] {
        IDLE,
        DIV_WAIT,
        TRAP,
        TRAP_DRAIN
    } state_e;

    localparam int WC_W = $clog2(DIV_MAX_CYC) + 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(DIV_MAX_CYC - 1);

    state_e            state_q, state_d;
    logic [WC_W-1:0]   wcnt_q, wcnt_d;
    logic [ADDR_W-1:0] vec_q, vec_d;
    logic [CNT_W-1:0]  scnt_q, scnt_d;

    logic rs1_hit, rs2_hit, load_use;
    logic hold_pc, hold_if_id, hold_id_ex;
    logic flush_if_id, flush_id_ex, redirect;
    logic div_kill, div_timeout;
    logic [ADDR_W-1:0] redir_addr;

    assign rs1_hit  = id_reg1_read_i && (id_reg1_raddr_i == ex_wd_i);
    assign rs2_hit  = id_reg2_read_i && (id_reg2_raddr_i == ex_wd_i);
    assign load_use = ex_load_i && (ex_wd_i != 5'd0) && (rs1_hit || rs2_hit);

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        vec_d       = vec_q;
        hold_pc     = 1'b0;
        hold_if_id  = 1'b0;
        hold_id_ex  = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        redirect    = 1'b0;
        redir_addr  = '0;
        div_kill    = 1'b0;
        div_timeout = 1'b0;
        if (trap_req_i) begin
            state_d     = TRAP;
            vec_d       = trap_vec_i;
            hold_pc     = 1'b1;
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
            div_kill    = (state_q == DIV_WAIT);
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (jump_flag_i) begin
                        redirect    = 1'b1;
                        redir_addr  = jump_addr_i;
                        flush_if_id = 1'b1;
                        flush_id_ex = 1'b1;
                    end else if (load_use) begin
                        hold_pc     = 1'b1;
                        hold_if_id  = 1'b1;
                        flush_id_ex = 1'b1;
                    end
                    if (div_start_i) begin
                        state_d = DIV_WAIT;
                        wcnt_d  = '0;
                    end
                end
                DIV_WAIT: begin
                    wcnt_d = wcnt_q + 1'b1;
                    if (div_ready_i) begin
                        state_d = IDLE;
                    end else begin
                        hold_pc    = 1'b1;
                        hold_if_id = 1'b1;
                        hold_id_ex = 1'b1;
                        // last allowed cycle without a result: abort the divide
                        if (wcnt_q == WC_LAST) begin
                            div_timeout = 1'b1;
                            div_kill    = 1'b1;
                            state_d     = IDLE;
                        end
                    end
                end
                TRAP: begin
                    redirect    = 1'b1;
                    redir_addr  = vec_q;
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                    state_d     = TRAP_DRAIN;
                end
                TRAP_DRAIN: begin
                    flush_if_id = 1'b1;
                    state_d     = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        scnt_d = scnt_q;
        if (hold_pc && (scnt_q != {CNT_W{1'b1}})) begin
            scnt_d = scnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            vec_q   <= '0;
            scnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            vec_q   <= vec_d;
            scnt_q  <= scnt_d;
        end
    end

    assign hold_pc_o       = rst_n & hold_pc;
    assign hold_if_id_o    = rst_n & hold_if_id;
    assign hold_id_ex_o    = rst_n & hold_id_ex;
    assign flush_if_id_o   = rst_n & flush_if_id;
    assign flush_id_ex_o   = rst_n & flush_id_ex;
    assign redirect_o      = rst_n & redirect;
    assign redirect_addr_o = rst_n ? redir_addr : '0;
    assign div_kill_o      = rst_n & div_kill;
    assign div_timeout_o   = rst_n & div_timeout;
    assign stall_cnt_o     = rst_n ? scnt_q : '0;

endmodule
